// File: rtl/sysbus_pkg.sv
// Shared constants and FSM state type for the Sysbus arbiter slice.
package sysbus_pkg;
  localparam int   SB_BEATS  = 8;
  localparam int   SB_TAG_W  = 13;
  localparam int   SB_DIR    = SB_TAG_W - 1;
  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  typedef enum logic [2:0] {IDLE, REQ, WDATA, WAIT_RESP, RESP} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting client at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NCLI  = 2,
  parameter int PTR_W = (NCLI > 1) ? $clog2(NCLI) : 1
) (
  input  logic [NCLI-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [NCLI-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx
);
  logic [PTR_W-1:0] idx;

  always_comb begin
    valid   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NCLI);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end
endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the Sysbus between fetch and LSU: one line transaction at a time,
// request replay onto the bus and response steering back to the owner.
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int NCLI  = 2,
  parameter int TAG_W = SB_TAG_W,
  parameter int BEATS = SB_BEATS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCLI-1:0]       cli_reqcyc,
  input  logic [NCLI*64-1:0]    cli_req,
  input  logic [NCLI*TAG_W-1:0] cli_reqtag,
  output logic [NCLI-1:0]       cli_reqack,
  output logic [NCLI-1:0]       cli_respcyc,
  output logic [63:0]           cli_resp,
  output logic [TAG_W-1:0]      cli_resptag,
  output logic                  bus_reqcyc,
  output logic [63:0]           bus_req,
  output logic [TAG_W-1:0]      bus_reqtag,
  input  logic                  bus_reqack,
  input  logic                  bus_respcyc,
  input  logic [63:0]           bus_resp,
  input  logic [TAG_W-1:0]      bus_resptag,
  output logic                  bus_respack
);
  localparam int PTR_W = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam int CNT_W = $clog2(BEATS) + 1;

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [63:0]      req_q, req_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             gnt_valid;
  logic [NCLI-1:0]  gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic [63:0]      gnt_req;
  logic [TAG_W-1:0] gnt_tag;
  logic [NCLI-1:0]  owner_oh;
  logic             in_req, in_resp, resp_beat, last_beat;

  rr_arbiter #(.NCLI(NCLI), .PTR_W(PTR_W)) u_rr (
    .req     (cli_reqcyc),
    .ptr     (rr_ptr_q),
    .valid   (gnt_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    gnt_req = '0;
    gnt_tag = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      if (gnt[i]) begin
        gnt_req = cli_req[i*64 +: 64];
        gnt_tag = cli_reqtag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Everything below decodes registered state; only the write-data path and
  // the response beat are combinational pass-throughs.
  always_comb begin
    owner_oh    = NCLI'(1) << owner_q;
    in_req      = (state_q == REQ) || (state_q == WDATA);
    in_resp     = (state_q == WAIT_RESP) || (state_q == RESP);
    resp_beat   = in_resp && bus_respcyc;
    last_beat   = (beat_cnt_q == CNT_W'(BEATS - 1));

    bus_reqcyc  = in_req;
    bus_reqtag  = in_req ? tag_q : '0;
    bus_req     = (state_q == WDATA) ? cli_req[32'(owner_q)*64 +: 64] :
                  (state_q == REQ)   ? req_q : '0;
    cli_reqack  = (in_req && bus_reqack) ? owner_oh : '0;

    bus_respack = resp_beat;
    cli_respcyc = resp_beat ? owner_oh : '0;
    cli_resp    = resp_beat ? bus_resp : '0;
    cli_resptag = resp_beat ? bus_resptag : '0;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_d      = req_q;
    tag_d      = tag_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d  = gnt_idx;
          req_d    = gnt_req;
          tag_d    = gnt_tag;
          rr_ptr_d = (gnt_idx == PTR_W'(NCLI - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          beat_cnt_d = '0;
          state_d    = (tag_q[TAG_W-1] == DIR_WRITE) ? WDATA : WAIT_RESP;
        end
      end
      WDATA: begin
        if (bus_reqack) begin
          beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
          state_d    = last_beat ? IDLE : WDATA;
        end
      end
      WAIT_RESP, RESP: begin
        if (bus_respcyc) begin
          beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
          state_d    = last_beat ? IDLE : RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      req_q      <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      req_q      <= req_d;
      tag_q      <= tag_d;
    end
  end

  a_owner_holds_req: assert property (@(posedge clk) disable iff (!reset)
    in_req |-> cli_reqcyc[owner_q])
    else $error("sysbus_arbiter: owner dropped cli_reqcyc after grant");

  a_resp_in_read: assert property (@(posedge clk) disable iff (!reset)
    bus_respcyc |-> in_resp)
    else $warning("sysbus_arbiter: bus_respcyc outside a read transaction ignored");
endmodule
